// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions a raw mechanical push-button: 2-flop synchronizer, optional
//   polarity inversion, then a 4-state debounce FSM producing a debounced
//   level plus one-clock press/release pulses. An optional long-press
//   detector pulses once when a press has been held for LONG_CYCLES clocks.
//
//   Optional feature macro: BUTTON_COND_LONGPRESS_EN
//     defined   -> long-press counter built, btn_long active
//     undefined -> no long counter, btn_long tied to 0
//
// Parameters
//   DEBOUNCE_CYCLES  stable clocks needed to accept a level change (>= 2)
//   LONG_CYCLES      press duration, in clocks after btn_rise, for btn_long
//   ACTIVE_LOW       1 = raw button reads 0 when pressed
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   btn_in     raw asynchronous bouncing button
//   btn_level  debounced pressed level (registered)
//   btn_rise   one-clock pulse on accepted press (registered)
//   btn_fall   one-clock pulse on accepted release (registered)
//   btn_long   one-clock pulse when a press reaches LONG_CYCLES (registered)
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    localparam int   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Raw value the button shows when released; synchronizer resets to it.
    localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    logic          sync1, sync2;
    logic          pressed;
    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          level_d, rise_d, fall_d;

    // ---------------- synchronizer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign pressed = sync2 ^ IDLE_RAW;

    // ---------------- FSM state + registered outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            btn_level <= level_d;
            btn_rise  <= rise_d;
            btn_fall  <= fall_d;
        end
    end

    // Counter stops at CNT_LAST (the transition fires there), so it never wraps.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        level_d = btn_level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    // Bounce during release: back to held, level stays 1.
                    state_d = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef BUTTON_COND_LONGPRESS_EN
    // ---------------- long-press detector ----------------
    // Counts every clock spent in PRESSED/RELEASE_WAIT, i.e. starting the edge
    // after btn_rise, so the pulse lands LONG_CYCLES clocks after btn_rise.
    // Saturates at LONG_CYCLES so it fires at most once per press.
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] long_cnt;
    logic          held;

    assign held = (state == PRESSED) || (state == RELEASE_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_cnt <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= held && (long_cnt == LONG_LAST);
            if (state_d == IDLE)
                long_cnt <= '0;
            else if (held && long_cnt != LONG_MAX)
                long_cnt <= long_cnt + 1'b1;
        end
    end
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int LC = 20;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level, btn_rise, btn_fall, btn_long;

    int total = 0;
    int bad   = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC),
        .ACTIVE_LOW     (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_long (btn_long)
    );

    always #5 clk = ~clk;

    // One record per clock edge: input applied before the edge, outputs
    // expected just after it. Fields of exp: {level, rise, fall, long}.
    typedef struct {
        logic       btn;
        logic [3:0] exp;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic b, input logic [3:0] e, input string tag);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.btn = b;
            v.exp = e;
            v.tag = tag;
            vecs.push_back(v);
        end
    endtask

    function automatic logic [3:0] outs();
        return {btn_level, btn_rise, btn_fall, btn_long};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got lvl/rise/fall/long=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int long_cnt, long_pos, fall_seen;

    initial begin
        rst    = 1'b1;
        btn_in = 1'b0;

        // Glitch of 3 clocks: never accepted.
        add(3,  1'b0, 4'b0000, "idle");
        add(3,  1'b1, 4'b0000, "bounce3_hi");
        add(6,  1'b0, 4'b0000, "bounce3_lo");
        // Clean press: rise + level at edge 7, rise gone at edge 8.
        add(6,  1'b1, 4'b0000, "press_wait");
        add(1,  1'b1, 4'b1100, "press_edge7");
        add(3,  1'b1, 4'b1000, "press_held");
        // 2-clock release glitch: level stays, no fall, no second rise.
        add(2,  1'b0, 4'b1000, "rel_glitch_lo");
        add(6,  1'b1, 4'b1000, "rel_glitch_hi");
        // Clean release: fall + level drop at edge 7.
        add(6,  1'b0, 4'b1000, "release_wait");
        add(1,  1'b0, 4'b0010, "release_edge7");
        add(3,  1'b0, 4'b0000, "released");

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", outs(), 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            btn_in = vecs[i].btn;
            tick();
            chk(vecs[i].tag, outs(), vecs[i].exp);
        end

        // ---- long press: held 40 clocks after btn_rise ----
        btn_in = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("long_press_debounce", outs() & 4'b1100, (e == 7) ? 4'b1100 : 4'b0000);
        end
        long_cnt = 0;
        long_pos = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (btn_long) begin
                long_cnt++;
                long_pos = e;
            end
        end
`ifdef BUTTON_COND_LONGPRESS_EN
        chk("long_pulse_count", 4'(long_cnt), 4'd1);
        chk("long_pulse_pos", 4'(long_pos - 16), 4'(LC - 16));
`else
        chk("long_pulse_count", 4'(long_cnt), 4'd0);
`endif
        btn_in = 1'b0;
        fall_seen = 0;
        for (int e = 1; e <= 20 && fall_seen == 0; e++) begin
            tick();
            if (btn_fall) fall_seen = e;
        end
        chk("long_release_fall_edge", 4'(fall_seen), 4'd7);
        repeat (3) tick();

        // ---- reset while PRESSED: immediate clear, re-debounce from IDLE ----
        btn_in = 1'b1;
        repeat (10) tick();
        chk("pressed_before_rst", outs(), 4'b1000);
        #2 rst = 1'b1;
        #1 chk("rst_in_pressed_immediate", outs(), 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("rst_pressed_rearm", outs() & 4'b1110,
                (e < 7) ? 4'b0000 : (e == 7) ? 4'b1100 : 4'b1000);
        end

        // ---- reset while PRESS_WAIT ----
        btn_in = 1'b0;
        repeat (10) tick();
        chk("released_before_rst2", outs(), 4'b0000);
        btn_in = 1'b1;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1 chk("rst_in_press_wait", outs(), 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("rst_press_wait_rearm", outs() & 4'b1110,
                (e < 7) ? 4'b0000 : (e == 7) ? 4'b1100 : 4'b1000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // rise and fall must never coincide
    always @(negedge clk) begin
        if (!rst && btn_rise && btn_fall) begin
            total++;
            bad++;
            $display("FAIL rise_fall_overlap: got rise=%b fall=%b expected not both 1", btn_rise, btn_fall);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 120000, stable-input clocks needed to accept a level change (10 ms at 12 MHz); SHALL be >= 2.
REQ-002 Parameter: LONG_CYCLES, 12000000, press duration in clocks that triggers btn_long (1 s at 12 MHz); SHALL be > DEBOUNCE_CYCLES.
REQ-003 Parameter: ACTIVE_LOW, 0, 1 = raw button reads 0 when pressed.
REQ-004 Port: clk  input  1  12 MHz system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: btn_in  input  1  raw, asynchronous, bouncing button.
REQ-007 Port: btn_level  output  1  debounced pressed level; drives the go input of the downstream LED state machine.
REQ-008 Port: btn_rise  output  1  one-clock pulse on accepted press.
REQ-009 Port: btn_fall  output  1  one-clock pulse on accepted release.
REQ-010 Port: btn_long  output  1  one-clock pulse when a press reaches LONG_CYCLES.

Function
REQ-011 btn_in SHALL pass through a 2-flop synchronizer, then be inverted when ACTIVE_LOW=1, giving internal signal "pressed".
REQ-012 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; all outputs registered.
REQ-013 IDLE: pressed=1 -> PRESS_WAIT, debounce counter cleared to 0.
REQ-014 PRESS_WAIT: pressed=0 -> IDLE with no output change; counter == DEBOUNCE_CYCLES-1 with pressed=1 -> PRESSED, btn_level=1, btn_rise=1; otherwise counter +1.
REQ-015 PRESSED: pressed=0 -> RELEASE_WAIT, counter cleared to 0.
REQ-016 RELEASE_WAIT: pressed=1 -> PRESSED with no pulse and btn_level held 1; counter == DEBOUNCE_CYCLES-1 with pressed=0 -> IDLE, btn_level=0, btn_fall=1.
REQ-017 Latency: a clean edge first sampled at clock edge 1 SHALL change btn_level at edge DEBOUNCE_CYCLES+3; btn_rise/btn_fall SHALL assert on that same edge, for exactly one cycle.
REQ-018 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no btn_level change.
REQ-019 btn_rise and btn_fall SHALL never be high in the same cycle; at most one per accepted transition.
REQ-020 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)); counter SHALL never wrap.
REQ-021 Illegal state encodings SHALL return to IDLE on the next edge with all pulses 0.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, counters 0, btn_level=0, btn_rise=0, btn_fall=0, btn_long=0.
REQ-023 Synchronizer flops SHALL reset to the not-pressed raw value (ACTIVE_LOW).
REQ-024 Reset mid-PRESS_WAIT or mid-PRESSED SHALL discard the press; a still-held button after release of rst SHALL be re-debounced from IDLE and produce btn_rise.

Configuration
REQ-025 Macro BUTTON_COND_LONGPRESS_EN defined: long counter counts in PRESSED and RELEASE_WAIT from the btn_rise edge, cleared on entry to IDLE; btn_long pulses one cycle LONG_CYCLES clocks after btn_rise, at most once per press (counter saturates).
REQ-026 Macro undefined: no long counter is synthesized; btn_long SHALL be constant 0.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=0)
REQ-027 btn_in 0->1 held -> btn_level=1 and btn_rise=1 at edge 7, btn_rise=0 at edge 8.
REQ-028 btn_in high for 3 clocks then low -> btn_level, btn_rise, btn_fall stay 0 throughout.
REQ-029 Pressed, then btn_in low 2 clocks and high again -> btn_level stays 1, no btn_fall, no second btn_rise.
REQ-030 Pressed then released cleanly -> btn_fall one cycle at release edge 7, btn_level=0 same edge.
REQ-031 With macro: held 40 clocks after btn_rise -> exactly one btn_long pulse 20 clocks after btn_rise; without macro -> btn_long=0.
REQ-032 rst pulsed while in PRESS_WAIT with btn_in held 1 -> outputs 0 immediately; btn_rise at edge 7 after rst deasserts.
